// File: rtl/aibio_outclk_phsel_ctrl.sv
// aibio_outclk_phsel_ctrl
// Walks the 4-bit DLL output-clock phase-mux select toward a requested target. The code moves
// one phase per step, and the block waits a programmable settle interval after every step.
// o_clksel drives the phase mux i_clksel[3:0] directly.
//
// Configuration macro: AIBIO_PHSEL_SHORTPATH_EN
//   defined   - direction is the shortest path around the 16-phase ring. A tie at
//               distance 8 resolves up.
//   undefined - the code always steps up with wrap, and o_dir stays 1.
module aibio_outclk_phsel_ctrl #(
  parameter int unsigned     SETTLE_W = 4,
  parameter logic [3:0]      RST_CODE = 4'd0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                vddcq,
  input  logic                vss,
  input  logic                i_req,
  input  logic [3:0]          i_tgt_code,
  input  logic [SETTLE_W-1:0] i_settle_cyc,
  output logic [3:0]          o_clksel,
  output logic                o_busy,
  output logic                o_ack,
  output logic                o_dir
);

  typedef enum logic [1:0] {StIdle, StStep, StSettle, StDone} state_e;

  state_e              state_q;
  logic [3:0]          clksel_q;
  logic [3:0]          tgt_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] cnt_q;
  logic                busy_q;
  logic                ack_q;
  logic                dir_q;

  logic                dir_new;
  logic [3:0]          next_code;

  // The supply pins have no functional effect in this model.
  logic unused_pwr;
  assign unused_pwr = vddcq ^ vss;

`ifdef AIBIO_PHSEL_SHORTPATH_EN
  // Up-distance around the ring. Wrap comes for free from the 4-bit subtraction.
  logic [3:0] up_dist;
  assign up_dist   = i_tgt_code - clksel_q;
  assign dir_new   = (up_dist <= 4'd8);
  assign next_code = dir_q ? (clksel_q + 4'd1) : (clksel_q - 4'd1);
`else
  assign dir_new   = 1'b1;
  assign next_code = clksel_q + 4'd1;
`endif

  // Sequencer FSM. All outputs are registered here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      clksel_q <= RST_CODE;
      tgt_q    <= 4'd0;
      settle_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      dir_q    <= 1'b1;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_req) begin
            tgt_q    <= i_tgt_code;
            settle_q <= i_settle_cyc;
            busy_q   <= 1'b1;
            if (i_tgt_code == clksel_q) begin
              // Already at the target. Acknowledge without touching the code or direction.
              state_q <= StDone;
              ack_q   <= 1'b1;
            end else begin
              dir_q   <= dir_new;
              state_q <= StStep;
            end
          end
        end
        StStep: begin
          clksel_q <= next_code;
          cnt_q    <= settle_q;
          state_q  <= StSettle;
        end
        StSettle: begin
          if (cnt_q == '0) begin
            if (clksel_q == tgt_q) begin
              state_q <= StDone;
              ack_q   <= 1'b1;
            end else begin
              state_q <= StStep;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_clksel = clksel_q;
  assign o_busy   = busy_q;
  assign o_ack    = ack_q;
  assign o_dir    = dir_q;

endmodule

// File: tb/tb_aibio_outclk_phsel_ctrl.sv
// Self-checking bench for aibio_outclk_phsel_ctrl.
// The reference model derives the expected trajectory of every move in closed form from the
// start code, target and settle count. Honours AIBIO_PHSEL_SHORTPATH_EN like the design.
module tb_aibio_outclk_phsel_ctrl;

  logic       clk;
  logic       rst;
  logic       req;
  logic [3:0] tgt;
  logic [3:0] settle;
  logic [3:0] clksel;
  logic       busy;
  logic       ack;
  logic       dir;

  int errors = 0;
  int checks = 0;

  // Model state: the code and direction the DUT should hold while idle.
  logic [3:0] cur_code;
  logic       cur_dir;

  aibio_outclk_phsel_ctrl #(
    .SETTLE_W (4),
    .RST_CODE (4'd0)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .vddcq        (1'b1),
    .vss          (1'b0),
    .i_req        (req),
    .i_tgt_code   (tgt),
    .i_settle_cyc (settle),
    .o_clksel     (clksel),
    .o_busy       (busy),
    .o_ack        (ack),
    .o_dir        (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [3:0] e_code, input logic e_busy,
                             input logic e_ack, input logic e_dir);
    chk({tag, " clksel"}, clksel, e_code);
    chk({tag, " busy"}, {3'b0, busy}, {3'b0, e_busy});
    chk({tag, " ack"}, {3'b0, ack}, {3'b0, e_ack});
    chk({tag, " dir"}, {3'b0, dir}, {3'b0, e_dir});
  endtask

  // Holds reset for two edges, then checks the reset state. Ends #1 after an edge.
  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cur_code = 4'd0;
    cur_dir  = 1'b1;
    chk_outputs("reset", 4'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  // Issues one request and checks every cycle until idle. With junk set, random requests are
  // driven while busy and must be ignored. When abort_at >= 0, reset is asserted at that edge.
  task automatic do_move(input logic [3:0] t, input logic [3:0] s, input logic junk,
                         input int abort_at);
    int         du;
    int         d;
    int         per;
    int         total;
    int         steps;
    logic       up;
    logic [3:0] e_code;
    string      tag;
    du = (int'(t) - int'(cur_code) + 16) % 16;
`ifdef AIBIO_PHSEL_SHORTPATH_EN
    up = (du <= 8);
    d  = up ? du : 16 - du;
`else
    up = 1'b1;
    d  = du;
`endif
    if (d != 0) cur_dir = up;
    per   = int'(s) + 2;
    total = d * per;
    req    = 1'b1;
    tgt    = t;
    settle = s;
    for (int n = 0; n <= total + 1; n++) begin
      if (n == abort_at) rst = 1'b1;
      @(posedge clk);
      #1;
      tag = $sformatf("mv %0d->%0d s%0d n%0d", cur_code, t, s, n);
      if (n == abort_at) begin
        cur_code = 4'd0;
        cur_dir  = 1'b1;
        chk_outputs({tag, " abort"}, 4'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        req = 1'b0;
        return;
      end
      steps  = (n == 0) ? 0 : (((n - 1) / per + 1) < d ? ((n - 1) / per + 1) : d);
      e_code = up ? cur_code + 4'(steps) : cur_code - 4'(steps);
      chk_outputs(tag, e_code, n <= total, n == total, cur_dir);
      if (junk && n < total) begin
        req    = 1'($urandom_range(0, 1));
        tgt    = 4'($urandom_range(0, 15));
        settle = 4'($urandom_range(0, 15));
      end else begin
        req = 1'b0;
      end
    end
    cur_code = t;
  endtask

  initial begin
    rst    = 1'b1;
    req    = 1'b0;
    tgt    = 4'd0;
    settle = 4'd0;
    cur_code = 4'd0;
    cur_dir  = 1'b1;

    do_reset();

    // Basic up move with settle.
    do_move(4'd3, 4'd1, 1'b0, -1);
    // Down by one (or a long wrap when the short path is disabled), then 2->14.
    do_move(4'd2, 4'd0, 1'b0, -1);
    do_move(4'd14, 4'd0, 1'b0, -1);
    // Back to 0, then the tie at distance 8, then a same-code request.
    do_move(4'd0, 4'd0, 1'b0, -1);
    do_move(4'd8, 4'd0, 1'b0, -1);
    do_move(4'd8, 4'd0, 1'b0, -1);

    // Requests while busy are ignored.
    do_reset();
    do_move(4'd3, 4'd1, 1'b1, -1);

    // Reset mid-move, then confirm no stray ack and a clean follow-up move.
    do_reset();
    do_move(4'd6, 4'd1, 1'b0, 5);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_outputs("post-abort idle", 4'd0, 1'b0, 1'b0, 1'b1);
    end
    do_move(4'd6, 4'd1, 1'b0, -1);
    do_move(4'd15, 4'd2, 1'b0, -1);

    // Random moves, some with junk requests while busy.
    for (int i = 0; i < 24; i++) begin
      do_move(4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
